// File: rtl/fixed8_mac_sched_if.sv
// Bundle for the fixed-8 MAC scheduler: job command, operand stream, PE drive/return, result port.
// Latency: none (wiring only). Backpressure: valid/ready on cmd, op and res channels.
// Optional FIXED8_SCHED_PERF_EN adds the stall_cnt perf counter to the bundle.
interface fixed8_mac_sched_if #(
    parameter int COL_WIDTH = 11,
    parameter int LEN_W     = 8
);
    localparam int PSUM_W = 4 * COL_WIDTH;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_s_in;
    logic              cmd_s_weight;

    logic              op_valid;
    logic              op_ready;
    logic [7:0]        op_in;
    logic [7:0]        op_weight;

    logic [7:0]        pe_in;
    logic [7:0]        pe_weight;
    logic              pe_s_in;
    logic              pe_s_weight;
    logic [PSUM_W-1:0] pe_psum_in;
    logic [PSUM_W-1:0] pe_psum_fwd;

    logic              res_valid;
    logic              res_ready;
    logic [PSUM_W-1:0] res_data;

`ifdef FIXED8_SCHED_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    // Scheduler side
    modport slave (
        input  cmd_valid, cmd_len, cmd_s_in, cmd_s_weight,
        input  op_valid, op_in, op_weight,
        input  pe_psum_fwd,
        input  res_ready,
`ifdef FIXED8_SCHED_PERF_EN
        output stall_cnt,
`endif
        output cmd_ready, op_ready,
        output pe_in, pe_weight, pe_s_in, pe_s_weight, pe_psum_in,
        output res_valid, res_data
    );

    // Operand-buffer / PE / result-consumer side
    modport master (
        output cmd_valid, cmd_len, cmd_s_in, cmd_s_weight,
        output op_valid, op_in, op_weight,
        output pe_psum_fwd,
        output res_ready,
`ifdef FIXED8_SCHED_PERF_EN
        input  stall_cnt,
`endif
        input  cmd_ready, op_ready,
        input  pe_in, pe_weight, pe_s_in, pe_s_weight, pe_psum_in,
        input  res_valid, res_data
    );
endinterface

// File: rtl/fixed8_mac_sched.sv
// Sequences one dot-product job through a fixed-8 MAC PE and returns the accumulated sum.
// Latency: N beats + 1 flush cycle after cmd accept; res_valid at T+N+2 (+1 per operand stall).
// Backpressure: op stalls insert PE hold bubbles; result held in DONE until res_ready. Option: FIXED8_SCHED_PERF_EN.
module fixed8_mac_sched #(
    parameter int COL_WIDTH = 11,
    parameter int LEN_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fixed8_mac_sched_if.slave   bus
);
    localparam int PSUM_W = 4 * COL_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic              s_in_q;
    logic              s_weight_q;
    logic              first;
    logic [PSUM_W-1:0] res_q;

    logic              cmd_hs;
    logic              op_hs;
    logic              last_beat;

    assign cmd_hs    = (state == IDLE) && bus.cmd_valid;
    assign op_hs     = (state == RUN) && bus.op_valid;
    assign last_beat = op_hs && (cnt == (len_q - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            s_in_q     <= 1'b0;
            s_weight_q <= 1'b0;
            first      <= 1'b0;
            res_q      <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_hs) begin
                len_q      <= bus.cmd_len;
                s_in_q     <= bus.cmd_s_in;
                s_weight_q <= bus.cmd_s_weight;
                first      <= 1'b1;
                cnt        <= '0;
                res_q      <= '0;
            end
            if (op_hs) begin
                first <= 1'b0;
                cnt   <= cnt + 1'b1;
            end
            // PE output is one cycle behind the last beat, so capture during FLUSH
            if (state == FLUSH) begin
                res_q <= bus.pe_psum_fwd;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.cmd_ready   = 1'b0;
        bus.op_ready    = 1'b0;
        bus.pe_in       = '0;
        bus.pe_weight   = '0;
        bus.pe_s_in     = 1'b0;
        bus.pe_s_weight = 1'b0;
        bus.pe_psum_in  = '0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = rst_n;
                if (bus.cmd_valid) begin
                    state_nxt = (bus.cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.op_ready    = 1'b1;
                bus.pe_s_in     = s_in_q;
                bus.pe_s_weight = s_weight_q;
                if (bus.op_valid) begin
                    bus.pe_in      = bus.op_in;
                    bus.pe_weight  = bus.op_weight;
                    bus.pe_psum_in = first ? '0 : bus.pe_psum_fwd;
                end else begin
                    // zero operands with feedback keep the PE sum unchanged
                    bus.pe_psum_in = bus.pe_psum_fwd;
                end
                if (last_beat) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                bus.pe_s_in     = s_in_q;
                bus.pe_s_weight = s_weight_q;
                bus.pe_psum_in  = bus.pe_psum_fwd;
                state_nxt       = DONE;
            end
            DONE: begin
                bus.pe_s_in     = s_in_q;
                bus.pe_s_weight = s_weight_q;
                bus.pe_psum_in  = bus.pe_psum_fwd;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = res_q;

`ifdef FIXED8_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (cmd_hs) begin
            stall_q <= '0;
        end else if ((state == RUN) && !bus.op_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fixed8_mac_sched.sv
// Bench for fixed8_mac_sched: behavioural fixed-8 PE model plus an expected-result queue.
module tb_fixed8_mac_sched;
    localparam int COL_WIDTH = 11;
    localparam int LEN_W     = 8;
    localparam int PSUM_W    = 4 * COL_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fixed8_mac_sched_if #(.COL_WIDTH(COL_WIDTH), .LEN_W(LEN_W)) ifc ();

    fixed8_mac_sched #(.COL_WIDTH(COL_WIDTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [PSUM_W-1:0] pmul(input logic [7:0] a, input logic [7:0] w,
                                               input logic sa, input logic sw);
        logic signed [9:0]  ax;
        logic signed [9:0]  wx;
        logic signed [19:0] p;
        ax = $signed({{2{sa & a[7]}}, a});
        wx = $signed({{2{sw & w[7]}}, w});
        p  = ax * wx;
        return {{(PSUM_W-20){p[19]}}, p};
    endfunction

    // PE: psum_fwd registered every clock, no enable, no reset
    logic [PSUM_W-1:0] pe_fwd = '0;
    always @(posedge clk)
        pe_fwd <= ifc.pe_psum_in + pmul(ifc.pe_in, ifc.pe_weight, ifc.pe_s_in, ifc.pe_s_weight);
    assign ifc.pe_psum_fwd = pe_fwd;

    logic [7:0]        qa[$];
    logic [7:0]        qw[$];
    int                qg[$];
    logic [PSUM_W-1:0] exp_q[$];
    int                exp_lat_q[$];

    bit op_rdy_seen = 1'b0;
    always @(negedge clk) if (ifc.op_ready) op_rdy_seen = 1'b1;

    bit sign_mon = 1'b0;
    bit mon_si   = 1'b0;
    bit mon_sw   = 1'b0;
    int sign_samples = 0;
    int sign_bad     = 0;
    always @(negedge clk) begin
        if (sign_mon && rst_n) begin
            sign_samples++;
            if (ifc.cmd_ready) begin
                if (ifc.pe_s_in !== 1'b0 || ifc.pe_s_weight !== 1'b0) sign_bad++;
            end else if (ifc.pe_s_in !== mon_si || ifc.pe_s_weight !== mon_sw) begin
                sign_bad++;
            end
        end
    end

    // Drives one job from the qa/qw/qg tables; returns when res_valid rises or the budget expires.
    task automatic drive_job(input int len, input bit sa, input bit sw,
                             output logic [PSUM_W-1:0] got, output int lat, output logic vld);
        logic [PSUM_W-1:0] e;
        int stalls;
        int waited;
        e = '0;
        stalls = 0;
        waited = 0;
        for (int i = 0; i < qa.size(); i++) begin
            e += pmul(qa[i], qw[i], sa, sw);
            stalls += qg[i];
        end
        exp_q.push_back(e);
        exp_lat_q.push_back((len == 0) ? 0 : len + 1 + stalls);
        ifc.cmd_valid    = 1'b1;
        ifc.cmd_len      = LEN_W'(len);
        ifc.cmd_s_in     = sa;
        ifc.cmd_s_weight = sw;
        while (!ifc.cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < qa.size(); i++) begin
            repeat (qg[i]) begin
                ifc.op_valid = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
            ifc.op_valid  = 1'b1;
            ifc.op_in     = qa[i];
            ifc.op_weight = qw[i];
            @(posedge clk); #1;
            lat++;
        end
        ifc.op_valid = 1'b0;
        while (!ifc.res_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        got = ifc.res_data;
        vld = ifc.res_valid;
        qa.delete();
        qw.delete();
        qg.delete();
    endtask

    task automatic collect_res();
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [108:0] outs;
        #1 rst_n = 1'b0;
        #2;
        outs = {ifc.cmd_ready, ifc.op_ready, ifc.pe_in, ifc.pe_weight, ifc.pe_s_in,
                ifc.pe_s_weight, ifc.pe_psum_in, ifc.res_valid, ifc.res_data};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
`ifdef FIXED8_SCHED_PERF_EN
        n_tests++;
        if (ifc.stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt got=%0d want=0", ifc.stall_cnt);
        end
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (ifc.cmd_ready !== 1'b1 || ifc.res_valid !== 1'b0 || ifc.op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got cmd_ready=%b res_valid=%b op_ready=%b want 1/0/0",
                     ifc.cmd_ready, ifc.res_valid, ifc.op_ready);
        end
    endtask

    task automatic test_basic();
        logic [PSUM_W-1:0] got;
        logic [PSUM_W-1:0] e;
        int lat;
        int el;
        logic vld;
        qa = '{8'd1, 8'd3, 8'd5};
        qw = '{8'd2, 8'd4, 8'd6};
        qg = '{0, 0, 0};
        drive_job(3, 1'b0, 1'b0, got, lat, vld);
        e  = exp_q.pop_front();
        el = exp_lat_q.pop_front();
        n_tests++;
        if (vld !== 1'b1 || got !== e || got !== 44'd44) begin
            n_fail++;
            $display("FAIL basic_sum got=%0d vld=%b want=%0d", got, vld, e);
        end
        n_tests++;
        if (lat !== el || lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency got=%0d edges want=%0d", lat, el);
        end
        collect_res();
        n_tests++;
        if (ifc.cmd_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release got cmd_ready=%b res_valid=%b want 1/0",
                     ifc.cmd_ready, ifc.res_valid);
        end
    endtask

    task automatic test_stall();
        logic [PSUM_W-1:0] got;
        logic [PSUM_W-1:0] e;
        int lat;
        int el;
        logic vld;
        qa = '{8'd255, 8'd255};
        qw = '{8'd255, 8'd255};
        qg = '{0, 3};
        drive_job(2, 1'b0, 1'b0, got, lat, vld);
        e  = exp_q.pop_front();
        el = exp_lat_q.pop_front();
        n_tests++;
        if (vld !== 1'b1 || got !== e || got !== 44'd130050) begin
            n_fail++;
            $display("FAIL stall_sum got=%0d vld=%b want=%0d", got, vld, e);
        end
        n_tests++;
        if (lat !== el) begin
            n_fail++;
            $display("FAIL stall_latency got=%0d want=%0d", lat, el);
        end
`ifdef FIXED8_SCHED_PERF_EN
        n_tests++;
        if (ifc.stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_cnt got=%0d want=3", ifc.stall_cnt);
        end
`endif
        collect_res();
    endtask

    task automatic test_zero_len();
        logic [PSUM_W-1:0] got;
        logic [PSUM_W-1:0] e;
        int lat;
        int el;
        logic vld;
        op_rdy_seen  = 1'b0;
        ifc.op_valid = 1'b1;
        ifc.op_in    = 8'd9;
        drive_job(0, 1'b0, 1'b0, got, lat, vld);
        e  = exp_q.pop_front();
        el = exp_lat_q.pop_front();
        n_tests++;
        if (vld !== 1'b1 || lat !== el || got !== e) begin
            n_fail++;
            $display("FAIL zero_len got data=%0d lat=%0d vld=%b want data=%0d lat=%0d vld=1",
                     got, lat, vld, e, el);
        end
        ifc.op_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 ifc.op_valid = 1'b0;
        collect_res();
        n_tests++;
        if (op_rdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_op_ready got seen=%b want=0", op_rdy_seen);
        end
    endtask

    task automatic test_hold();
        logic [PSUM_W-1:0] got;
        logic [PSUM_W-1:0] e;
        int lat;
        logic vld;
        qa = '{8'd10, 8'd20};
        qw = '{8'd3, 8'd4};
        qg = '{1, 0};
        drive_job(2, 1'b0, 1'b0, got, lat, vld);
        e = exp_q.pop_front();
        void'(exp_lat_q.pop_front());
        ifc.cmd_valid = 1'b1;
        ifc.cmd_len   = 8'd1;
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (ifc.res_valid !== 1'b1 || ifc.res_data !== e || ifc.cmd_ready !== 1'b0 ||
                ifc.pe_psum_in !== ifc.pe_psum_fwd) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got vld=%b data=%0d cmd_ready=%b psum_in=%h fwd=%h want 1/%0d/0/equal",
                         c, ifc.res_valid, ifc.res_data, ifc.cmd_ready,
                         ifc.pe_psum_in, ifc.pe_psum_fwd, e);
            end
            @(posedge clk); #1;
        end
        ifc.cmd_valid = 1'b0;
        collect_res();
        n_tests++;
        if (ifc.cmd_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release got cmd_ready=%b res_valid=%b want 1/0",
                     ifc.cmd_ready, ifc.res_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [PSUM_W-1:0] got;
        logic [PSUM_W-1:0] e;
        logic [108:0] outs;
        int lat;
        logic vld;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_len   = 8'd4;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        ifc.op_valid  = 1'b1;
        ifc.op_in     = 8'd11;
        ifc.op_weight = 8'd13;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        outs = {ifc.cmd_ready, ifc.op_ready, ifc.pe_in, ifc.pe_weight, ifc.pe_s_in,
                ifc.pe_s_weight, ifc.pe_psum_in, ifc.res_valid, ifc.res_data};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs got=%h want=0", outs);
        end
        ifc.op_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        qa = '{8'd7};
        qw = '{8'd9};
        qg = '{0};
        drive_job(1, 1'b0, 1'b0, got, lat, vld);
        e = exp_q.pop_front();
        void'(exp_lat_q.pop_front());
        n_tests++;
        if (vld !== 1'b1 || got !== e || got !== 44'd63) begin
            n_fail++;
            $display("FAIL midrun_new_job got=%0d vld=%b want=%0d", got, vld, e);
        end
        collect_res();
    endtask

    task automatic test_sign();
        logic [PSUM_W-1:0] got;
        logic [PSUM_W-1:0] e;
        logic [PSUM_W-1:0] c;
        int lat;
        logic vld;
        c = '0;
        c = c - 44'd399;
        mon_si = 1'b1;
        mon_sw = 1'b0;
        sign_samples = 0;
        sign_bad = 0;
        sign_mon = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        qa = '{8'hFD, 8'h80};
        qw = '{8'd5, 8'd3};
        qg = '{0, 2};
        drive_job(2, 1'b1, 1'b0, got, lat, vld);
        e = exp_q.pop_front();
        void'(exp_lat_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        collect_res();
        repeat (2) @(posedge clk);
        #1;
        sign_mon = 1'b0;
        n_tests++;
        if (vld !== 1'b1 || got !== e || got !== c) begin
            n_fail++;
            $display("FAIL sign_sum got=%h vld=%b want=%h", got, vld, c);
        end
        n_tests++;
        if (sign_bad !== 0 || sign_samples < 10) begin
            n_fail++;
            $display("FAIL sign_bits got bad=%0d of %0d samples want 0 bad", sign_bad, sign_samples);
        end
    endtask

    initial begin
        ifc.cmd_valid    = 1'b0;
        ifc.cmd_len      = '0;
        ifc.cmd_s_in     = 1'b0;
        ifc.cmd_s_weight = 1'b0;
        ifc.op_valid     = 1'b0;
        ifc.op_in        = '0;
        ifc.op_weight    = '0;
        ifc.res_ready    = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_hold();
        test_reset_mid_run();
        test_sign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
